pixel_bit_arbiter: RTL and testbench

Round-robin scheduler that shares one serial-to-parallel bit packer (`pixel_convert_bit`) between two bit-serial pixel sources. It drives the packer's `en`/`din` pins in whole-word bursts, so the packer's internal bit counter never sees a partial word from a mixed source. Each packed word comes back tagged with the channel that produced it. The block sits between the per-channel bit-plane readers and the pixel word pipeline.

---
 rtl/pixel_bit_arbiter.sv | 141 ++++++++++++++
 tb/tb_pixel_bit_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_bit_arbiter.sv
// pixel_bit_arbiter: round-robin sharing of one serial-to-parallel bit packer
//   between two bit-serial pixel sources, one BURST_WORDS-word burst per grant.
// Latency: grant 1 cycle after vld in IDLE; tagged word 3 cycles after its last bit.
// Backpressure: only the granted channel sees rdy; a vld drop stalls the packer (no timeout).
// Ports:
//   clk, rst_n          clock, async active-low reset (shared with the packer)
//   vldN/dinN/rdyN      per-channel serial bit stream, MSB of each word first
//   cvt_en/cvt_din      drive the packer's en/din pins
//   cvt_dout/cvt_oe     packed word and its strobe coming back from the packer
//   out_vld/out_data/out_ch  tagged packed word, one-cycle strobe
//   out_err             sticky: packer produced a word with no tag pending
`ifndef CACHE_WIDTH
`define CACHE_WIDTH 8
`endif

module pixel_bit_arbiter #(
  parameter int WORD_BITS   = `CACHE_WIDTH,
  parameter int BURST_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld0,
  input  logic                 vld1,
  input  logic                 din0,
  input  logic                 din1,
  output logic                 rdy0,
  output logic                 rdy1,
  output logic                 cvt_en,
  output logic                 cvt_din,
  input  logic [WORD_BITS-1:0] cvt_dout,
  input  logic                 cvt_oe,
  output logic                 out_vld,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 out_ch,
  output logic                 out_err
);

  localparam int BW = (WORD_BITS   > 1) ? $clog2(WORD_BITS)   : 1;
  localparam int WW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_nxt;
  logic            cur_ch, cur_ch_nxt;
  logic            rr_ptr, rr_ptr_nxt;   // channel favoured on a tie
  logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [WW-1:0]   word_cnt, word_cnt_nxt;
  logic            word_end;             // last bit of a word accepted this cycle

  // Tag delay line, two stages to line up with the packer's en->oe latency.
  logic            tag1_vld, tag1_ch;
  logic            tag2_vld, tag2_ch;

  always_comb begin
    state_nxt    = state;
    cur_ch_nxt   = cur_ch;
    rr_ptr_nxt   = rr_ptr;
    bit_cnt_nxt  = bit_cnt;
    word_cnt_nxt = word_cnt;
    rdy0         = 1'b0;
    rdy1         = 1'b0;
    cvt_en       = 1'b0;
    cvt_din      = 1'b0;
    word_end     = 1'b0;
    case (state)
      IDLE: begin
        if (vld0 || vld1) begin
          state_nxt    = XFER;
          bit_cnt_nxt  = '0;
          word_cnt_nxt = '0;
          cur_ch_nxt   = (vld0 && vld1) ? rr_ptr : vld1;
        end
      end
      XFER: begin
        rdy0    = ~cur_ch;
        rdy1    = cur_ch;
        cvt_en  = cur_ch ? vld1 : vld0;
        cvt_din = cur_ch ? din1 : din0;
        if (cvt_en) begin
          if (bit_cnt == BW'(WORD_BITS - 1)) begin
            word_end    = 1'b1;
            bit_cnt_nxt = '0;
            if (word_cnt == WW'(BURST_WORDS - 1)) begin
              // Burst done: the IDLE cycle that follows is the bubble.
              state_nxt    = IDLE;
              word_cnt_nxt = '0;
              rr_ptr_nxt   = ~cur_ch;
            end else begin
              word_cnt_nxt = word_cnt + WW'(1);
            end
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_ch   <= 1'b0;
      rr_ptr   <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cur_ch   <= cur_ch_nxt;
      rr_ptr   <= rr_ptr_nxt;
      bit_cnt  <= bit_cnt_nxt;
      word_cnt <= word_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_vld <= 1'b0;
      tag1_ch  <= 1'b0;
      tag2_vld <= 1'b0;
      tag2_ch  <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_ch   <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      tag1_vld <= word_end;
      tag1_ch  <= cur_ch;
      tag2_vld <= tag1_vld;
      tag2_ch  <= tag1_ch;
      out_vld  <= cvt_oe;
      if (cvt_oe) begin
        out_data <= cvt_dout;
        out_ch   <= tag2_ch;
        // A packer word with no tag means the packer and this block lost sync.
        if (!tag2_vld) out_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_bit_arbiter.sv
module tb_pixel_bit_arbiter;

  localparam int W = 8;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vld0, vld1, din0, din1;
  logic         rdy0, rdy1, cvt_en, cvt_din;
  logic [W-1:0] cvt_dout;
  logic         cvt_oe;
  logic         out_vld;
  logic [W-1:0] out_data;
  logic         out_ch;
  logic         out_err;
  logic         inj_oe;

  pixel_bit_arbiter #(.WORD_BITS(W), .BURST_WORDS(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .vld0(vld0), .vld1(vld1), .din0(din0), .din1(din1),
    .rdy0(rdy0), .rdy1(rdy1),
    .cvt_en(cvt_en), .cvt_din(cvt_din),
    .cvt_dout(cvt_dout), .cvt_oe(cvt_oe),
    .out_vld(out_vld), .out_data(out_data), .out_ch(out_ch), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Packer model: shifts MSB-first on en, strobes oe two cycles after the last bit.
  logic [W-1:0] pk_sh, pk_dout;
  int           pk_cnt;
  logic         pk_pend, pk_oe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_sh <= '0; pk_dout <= '0; pk_cnt <= 0; pk_pend <= 1'b0; pk_oe <= 1'b0;
    end else begin
      pk_oe   <= pk_pend;
      pk_pend <= 1'b0;
      if (pk_pend) pk_dout <= pk_sh;
      if (cvt_en) begin
        pk_sh <= {pk_sh[W-2:0], cvt_din};
        if (pk_cnt == W-1) begin
          pk_cnt  <= 0;
          pk_pend <= 1'b1;
        end else begin
          pk_cnt <= pk_cnt + 1;
        end
      end
    end
  end
  assign cvt_oe   = pk_oe | inj_oe;
  assign cvt_dout = pk_dout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         ch;
    int           gap;   // required cycles since previous out_vld, -1 = not checked
    bit           lat;   // word came from real bits: check 3-cycle latency
  } exp_t;

  exp_t exp_q[$];
  bit   q0[$], q1[$];
  int   lat_q[$];
  int   hold0 = 0, stall_at0 = -1;
  int   acc_cnt0 = 0, acc_cnt1 = 0;
  int   first_rdy1 = -1, last_acc0 = -1;
  int   en_low = 0, rdy_hi0 = 0;
  int   last_vld_cyc = -1;

  task automatic send_word(input logic ch, input logic [W-1:0] w, input int gap);
    exp_t e;
    for (int i = W-1; i >= 0; i--) begin
      if (ch) q1.push_back(w[i]);
      else    q0.push_back(w[i]);
    end
    e.data = w; e.ch = ch; e.gap = gap; e.lat = 1'b1;
    exp_q.push_back(e);
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Source feeder: samples handshakes at negedge, updates vld/din just after posedge.
  initial begin : feeder
    bit a0, a1;
    vld0 = 1'b0; vld1 = 1'b0; din0 = 1'b0; din1 = 1'b0;
    forever begin
      @(negedge clk);
      a0 = rst_n && vld0 && rdy0;
      a1 = rst_n && vld1 && rdy1;
      if (a0) begin
        acc_cnt0++;
        last_acc0 = cyc;
        if (acc_cnt0 % W == 0) lat_q.push_back(cyc);
      end
      if (a1) begin
        acc_cnt1++;
        if (acc_cnt1 % W == 0) lat_q.push_back(cyc);
      end
      if (rst_n && rdy1 && first_rdy1 < 0) first_rdy1 = cyc;
      if (rst_n && rdy0 && !cvt_en) en_low++;
      if (rst_n && rdy0) rdy_hi0++;
      @(posedge clk);
      #1;
      if (a0 && q0.size() > 0) begin
        void'(q0.pop_front());
        if (acc_cnt0 == stall_at0) hold0 = 5;
      end
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      if (hold0 > 0) begin
        vld0 = 1'b0;
        hold0--;
      end else begin
        vld0 = (q0.size() > 0);
      end
      din0 = (q0.size() > 0) ? q0[0] : 1'b0;
      vld1 = (q1.size() > 0);
      din1 = (q1.size() > 0) ? q1[0] : 1'b0;
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_vld: got data=%0h ch=%0d required no word", out_data, out_ch);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_ch", out_ch, e.ch);
          if (e.gap >= 0) chk("out_gap", cyc - last_vld_cyc, e.gap);
          if (e.lat) begin
            if (lat_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL word_latency: got out_vld with no word-final bit, required one");
            end else begin
              chk("word_latency", cyc - lat_q.pop_front(), 3);
            end
          end
        end
        last_vld_cyc = cyc;
      end
    end
  end

  task automatic clear_tb_state();
    q0.delete(); q1.delete(); exp_q.delete(); lat_q.delete();
    hold0 = 0; stall_at0 = -1;
    acc_cnt0 = 0; acc_cnt1 = 0;
    first_rdy1 = -1; last_acc0 = -1;
    en_low = 0; rdy_hi0 = 0; last_vld_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_tb_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy0"}, rdy0, 0);
    chk({tag, "_rdy1"}, rdy1, 0);
    chk({tag, "_cvt_en"}, cvt_en, 0);
    chk({tag, "_cvt_din"}, cvt_din, 0);
    chk({tag, "_out_vld"}, out_vld, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_ch"}, out_ch, 0);
    chk({tag, "_out_err"}, out_err, 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0) begin
      failures++;
      $display("FAIL drain_%s: got %0d words pending required 0", name, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_acc0(input int target, input string name);
    int n = 0;
    while (acc_cnt0 < target && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (acc_cnt0 < target) begin
      failures++;
      $display("FAIL wait_%s: got %0d bits accepted required %0d", name, acc_cnt0, target);
    end
  endtask

  initial begin : stim
    exp_t e;
    rst_n  = 1'b0;
    inj_oe = 1'b0;
    #1;
    check_zero("reset");
    do_reset();
    @(negedge clk);
    check_zero("post_reset_idle");

    // Single channel: two bursts of two words, one bubble between bursts.
    do_reset();
    send_word(1'b0, 8'hA6, -1);
    send_word(1'b0, 8'hF0, 8);
    send_word(1'b0, 8'hC3, 9);
    send_word(1'b0, 8'h5A, 8);
    drain("single");
    chk("single_rdy0_cycles", rdy_hi0, 32);

    // Both channels valid from reset: out_ch order 0,0,1,1,0,0.
    rst_n = 1'b0;
    clear_tb_state();
    send_word(1'b0, 8'h11, -1);
    send_word(1'b0, 8'h22, 8);
    send_word(1'b1, 8'h81, 9);
    send_word(1'b1, 8'h7E, 8);
    send_word(1'b0, 8'h33, 9);
    send_word(1'b0, 8'h44, 8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain("both");

    // Stall: vld0 low for 5 cycles after bit 3 of the second word.
    do_reset();
    stall_at0 = W + 3;
    send_word(1'b0, 8'h96, -1);
    send_word(1'b0, 8'h2D, 13);
    drain("stall");
    chk("stall_en_low_cycles", en_low, 5);

    // Late request: ch1 arrives mid ch0 burst, granted after burst + bubble.
    do_reset();
    send_word(1'b0, 8'hA5, -1);
    send_word(1'b0, 8'h0F, 8);
    wait_acc0(4, "late_mid");
    send_word(1'b1, 8'h69, 9);
    send_word(1'b1, 8'h96, 8);
    drain("late");
    chk("late_grant_after_bubble", first_rdy1 - last_acc0, 2);

    // Reset mid-word: 5 bits in, reset, then a clean aligned word.
    do_reset();
    for (int i = 0; i < 5; i++) q0.push_back(1'b1);
    wait_acc0(5, "rst_mid");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy0", rdy0, 0);
    chk("midrst_cvt_en", cvt_en, 0);
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_out_err", out_err, 0);
    clear_tb_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(1'b0, 8'h3C, -1);
    drain("rst_mid");
    chk("midrst_err_after", out_err, 0);

    // Tag error: a packer strobe with no tag in flight; out_err is sticky.
    do_reset();
    @(posedge clk);
    #1;
    e.data = 8'h00; e.ch = 1'b0; e.gap = -1; e.lat = 1'b0;
    exp_q.push_back(e);
    inj_oe = 1'b1;
    @(posedge clk);
    #1;
    inj_oe = 1'b0;
    repeat (2) @(negedge clk);
    chk("tag_err_set", out_err, 1);
    send_word(1'b0, 8'h5A, -1);
    send_word(1'b0, 8'hC3, 8);
    drain("tag_err");
    chk("tag_err_sticky", out_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
